// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 16-bit five-stage pipeline.
// Drives the PC write enable, the four inter-stage buffer load enables and
// the bubble strobes, and tracks which stages hold a live instruction.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall / flush performance counters).
module pipe_ctrl #(
    parameter int FLUSH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_wait,
    input  logic        redirect,
    input  logic        load_use,
    input  logic        halt_op,
    output logic        pc_we,
    output logic        call_if_id,
    output logic        call_id_ex,
    output logic        call_ex_mem,
    output logic        call_mem_wb,
    output logic        kill_if_id,
    output logic        kill_id_ex,
    output logic [3:0]  stage_valid,
    output logic        running,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [3:0] valid_q, valid_next;

    assign stage_valid = valid_q;

    // Control decode: buffer enables, bubbles and next state from state plus hazards.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_next  = state;
        pc_we       = 1'b0;
        call_if_id  = 1'b0;
        call_id_ex  = 1'b0;
        call_ex_mem = 1'b0;
        call_mem_wb = 1'b0;
        kill_if_id  = 1'b0;
        kill_id_ex  = 1'b0;
        running     = 1'b0;

        case (state)
            IDLE, HALTED: begin
                if (start) state_next = RUN;
            end

            RUN: begin
                running = 1'b1;
                if (mem_wait) begin
                    // Full freeze: nothing advances, valid bits hold.
                end else if (redirect) begin
                    // Taken branch wins over a load-use bubble in the same cycle.
                    pc_we       = 1'b1;
                    call_if_id  = 1'b1;
                    call_id_ex  = 1'b1;
                    call_ex_mem = 1'b1;
                    call_mem_wb = 1'b1;
                    kill_if_id  = 1'b1;
                    kill_id_ex  = (FLUSH_SLOTS >= 2);
                end else if (halt_op) begin
                    // Stop fetching; the halt itself moves on while IF/ID takes a bubble.
                    call_if_id  = 1'b1;
                    call_id_ex  = 1'b1;
                    call_ex_mem = 1'b1;
                    call_mem_wb = 1'b1;
                    kill_if_id  = 1'b1;
                    state_next  = DRAIN;
                end else if (load_use) begin
                    // Hold PC and IF/ID, push a bubble into ID/EX.
                    call_id_ex  = 1'b1;
                    call_ex_mem = 1'b1;
                    call_mem_wb = 1'b1;
                    kill_id_ex  = 1'b1;
                end else begin
                    pc_we       = 1'b1;
                    call_if_id  = 1'b1;
                    call_id_ex  = 1'b1;
                    call_ex_mem = 1'b1;
                    call_mem_wb = 1'b1;
                end
            end

            DRAIN: begin
                running = 1'b1;
                if (!mem_wait) begin
                    call_if_id  = 1'b1;
                    call_id_ex  = 1'b1;
                    call_ex_mem = 1'b1;
                    call_mem_wb = 1'b1;
                    kill_if_id  = 1'b1;
                end
                if (valid_next == 4'b0000) state_next = HALTED;
            end

            default: state_next = IDLE;
        endcase
    end

    // Valid-bit shift: a stage only takes its upstream bit when its buffer loads.
    always_comb begin
        valid_next = valid_q;
        if (call_if_id)  valid_next[0] = (state == RUN) ? ~kill_if_id : 1'b0;
        if (call_id_ex)  valid_next[1] = valid_q[0] & ~kill_id_ex;
        if (call_ex_mem) valid_next[2] = valid_q[1];
        if (call_mem_wb) valid_next[3] = valid_q[2];
    end

    // State and valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state   <= IDLE;
            valid_q <= 4'b0000;
        end else begin
            state   <= state_next;
            valid_q <= valid_next;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_hit;
    logic flush_hit;

    // A stall cycle is a memory freeze or a load-use bubble that actually took effect.
    assign stall_hit = running &&
                       (mem_wait ||
                        ((state == RUN) && !redirect && !halt_op && load_use));
    assign flush_hit = (state == RUN) && !mem_wait && redirect;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 16'h0000;
            flush_count  <= 16'h0000;
        end else begin
            if (stall_hit && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'h0001;
            if (flush_hit && (flush_count  != 16'hFFFF)) flush_count  <= flush_count  + 16'h0001;
        end
    end
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule
